// File: rtl/lsu_port_pkg.sv
// Shared encodings for the load/store port: control codes, FSM states, timeout default.
package lsu_port_pkg;

   localparam int unsigned TIMEOUT_CYC_DEF = 255;

   localparam logic [2:0] TRIM_LW  = 3'b000;
   localparam logic [2:0] TRIM_LH  = 3'b001;
   localparam logic [2:0] TRIM_LB  = 3'b010;
   localparam logic [2:0] TRIM_LBU = 3'b011;
   localparam logic [2:0] TRIM_LHU = 3'b100;

   localparam logic [3:0] DM_NONE = 4'b0000;
   localparam logic [3:0] DM_SB   = 4'b0001;
   localparam logic [3:0] DM_SH   = 4'b0011;
   localparam logic [3:0] DM_SW   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } lsu_state_e;

endpackage

// File: rtl/lsu_load_trim.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module lsu_load_trim
   import lsu_port_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  trim_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(word_i >> {off_i, 3'b000});
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
      case (trim_i)
         TRIM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         TRIM_LBU: data_o = {24'd0, byte_sel};
         TRIM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
         TRIM_LHU: data_o = {16'd0, half_sel};
         TRIM_LW:  data_o = word_i;
         default:  data_o = word_i;  // reserved codes behave as LW
      endcase
   end

endmodule

// File: rtl/lsu_port.sv
// Load/store port: accepts one memory-stage operation, drives a held bus request, returns a trimmed response.
module lsu_port
   import lsu_port_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_load,
   input  logic [3:0]  dm_ctl,
   input  logic [2:0]  trim_ctl,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign_err,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   lsu_state_e       state_q, state_d;
   logic [31:0]      addr_q, wdata_q, rdata_q, trimmed;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_d;
   logic [2:0]       trim_q;
   logic             load_q, we_q, mis_q, berr_q;
   logic [CNT_W-1:0] cnt_q, cnt_inc;
   logic             accept, misalign, timeout_hit;

   assign accept      = (state_q == IDLE) && req_valid && (is_load || (dm_ctl != DM_NONE));
   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

   always_comb begin
      misalign = 1'b0;
      be_d     = is_load ? 4'b1111 : 4'(dm_ctl << addr[1:0]);
      wdata_d  = wdata;
      if (is_load) begin
         case (trim_ctl)
            TRIM_LH, TRIM_LHU: misalign = addr[0];
            TRIM_LB, TRIM_LBU: misalign = 1'b0;
            default:           misalign = |addr[1:0];
         endcase
      end else begin
         case (dm_ctl)
            DM_SH:   misalign = addr[0];
            DM_SW:   misalign = |addr[1:0];
            default: misalign = 1'b0;
         endcase
      end
      case (dm_ctl)
         DM_SB:   wdata_d = {4{wdata[7:0]}};
         DM_SH:   wdata_d = {2{wdata[15:0]}};
         default: wdata_d = wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = misalign ? RESP : BUSY;
         BUSY: if (mem_ack || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         trim_q  <= '0;
         load_q  <= 1'b0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         addr_q  <= addr;
         wdata_q <= wdata_d;
         rdata_q <= '0;
         be_q    <= be_d;
         trim_q  <= trim_ctl;
         load_q  <= is_load;
         we_q    <= ~is_load;
         mis_q   <= misalign;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (state_q == BUSY) begin
         if (mem_ack) begin
            rdata_q <= mem_rdata;
         end else begin
            cnt_q <= cnt_inc;
            if (timeout_hit) berr_q <= 1'b1;
         end
      end
   end

   lsu_load_trim u_trim (
      .word_i (rdata_q),
      .off_i  (addr_q[1:0]),
      .trim_i (trim_q),
      .data_o (trimmed)
   );

   always_comb begin
      req_ready    = (state_q == IDLE);
      mem_req      = (state_q == BUSY);
      rsp_valid    = (state_q == RESP);
      misalign_err = (state_q == RESP) && mis_q;
      bus_err      = (state_q == RESP) && berr_q;
      rsp_rdata    = ((state_q == RESP) && load_q && !mis_q && !berr_q) ? trimmed : '0;
      mem_we       = we_q;
      mem_be       = be_q;
      mem_addr     = addr_q[31:2];
      mem_wdata    = wdata_q;
   end

endmodule

// File: tb/tb_lsu_port.sv
// Directed and randomized checks of lsu_port against an arithmetic reference model.
module tb_lsu_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, is_load;
   logic [3:0]  dm_ctl;
   logic [2:0]  trim_ctl;
   logic [31:0] addr, wdata;
   logic        rsp_valid, misalign_err, bus_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_port #(.TIMEOUT_CYC(255)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .is_load(is_load), .dm_ctl(dm_ctl), .trim_ctl(trim_ctl),
      .addr(addr), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misalign_err(misalign_err), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit m_mis(bit ld, logic [3:0] dm, logic [2:0] tr, logic [31:0] a);
      int unsigned off = a % 4;
      if (ld) begin
         if (tr == 3'd1 || tr == 3'd4) return (off % 2) != 0;
         if (tr == 3'd2 || tr == 3'd3) return 1'b0;
         return off != 0;
      end
      if (dm == 4'b0011) return (off % 2) != 0;
      if (dm == 4'b1111) return off != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_be(bit ld, logic [3:0] dm, logic [31:0] a);
      int unsigned v;
      if (ld) return 32'd15;
      v = (int'(dm) * (1 << (a % 4))) % 16;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(logic [3:0] dm, logic [31:0] wd);
      if (dm == 4'b0001) return (wd % 256) * 32'h0101_0101;
      if (dm == 4'b0011) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] tr, logic [31:0] a, logic [31:0] rd);
      int unsigned off = a % 4;
      logic [31:0] b = (rd >> (8 * off)) % 256;
      logic [31:0] h = (rd >> (16 * (off / 2))) % 65536;
      case (tr)
         3'd2:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd3:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return h;
         default: return rd;
      endcase
   endfunction

   // Runs one accepted operation from its request cycle to the idle cycle after the response.
   task automatic run_op(input bit ld, input logic [3:0] dm, input logic [2:0] tr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int unsigned dly, input logic [31:0] rd);
      bit mis = m_mis(ld, dm, tr, a);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; is_load = ld; dm_ctl = dm; trim_ctl = tr; addr = a; wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom; wdata = $urandom;
      if (mis) begin
         check("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("mis_err", {31'd0, misalign_err}, 32'd1);
         check("mis_no_req", {31'd0, mem_req}, 32'd0);
         check("mis_rdata", rsp_rdata, 32'd0);
      end else begin
         check("busy_req", {31'd0, mem_req}, 32'd1);
         check("busy_we", {31'd0, mem_we}, {31'd0, ~ld});
         check("busy_be", {28'd0, mem_be}, m_be(ld, dm, a));
         check("busy_addr", {2'd0, mem_addr}, a / 4);
         if (!ld) check("busy_wdata", mem_wdata, m_wdata(dm, wd));
         for (int unsigned i = 0; i < dly; i++) begin
            @(negedge clk);
            check("wait_req", {31'd0, mem_req}, 32'd1);
            check("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
         end
         mem_ack = 1'b1; mem_rdata = rd;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = $urandom;
         check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("rsp_errs", {30'd0, misalign_err, bus_err}, 32'd0);
         check("rsp_rdata", rsp_rdata, ld ? m_load(tr, a, rd) : 32'd0);
      end
      @(negedge clk);
      check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int unsigned busy;
      logic [3:0]  dms [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
      rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; dm_ctl = '0; trim_ctl = '0;
      addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_flags", {27'd0, mem_req, mem_we, rsp_valid, misalign_err, bus_err}, 32'd0);
      check("rst_be", {28'd0, mem_be}, 32'd0);
      check("rst_addr", {2'd0, mem_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(1'b1, 4'b0000, 3'b010, 32'h0000_0103, 32'd0, 0, 32'h80FF_1234);
      check("lb_value", m_load(3'b010, 32'h103, 32'h80FF_1234), 32'hFFFF_FF80);
      run_op(1'b0, 4'b0011, 3'b000, 32'h0000_0202, 32'h0000_ABCD, 1, 32'd0);
      run_op(1'b1, 4'b0000, 3'b000, 32'h0000_0101, 32'd0, 0, 32'd0);

      // Neither load nor store: must be dropped silently.
      req_valid = 1'b1; is_load = 1'b0; dm_ctl = 4'b0000; addr = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("nop_quiet", {30'd0, mem_req, rsp_valid}, 32'd0);
         check("nop_ready", {31'd0, req_ready}, 32'd1);
         @(negedge clk);
      end

      // Ack while idle is ignored.
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack_ignored", {30'd0, mem_req, rsp_valid}, 32'd0);

      // Timeout with mem_ack held low.
      req_valid = 1'b1; is_load = 1'b1; trim_ctl = 3'b000; addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      busy = 0;
      for (int i = 0; i < 400; i++) begin
         if (rsp_valid) break;
         if (mem_req) busy++;
         @(negedge clk);
      end
      check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("to_busy_cycles", busy, 32'd255);
      check("to_bus_err", {30'd0, bus_err, misalign_err}, 32'd2);
      check("to_req_dropped", {31'd0, mem_req}, 32'd0);
      check("to_rdata", rsp_rdata, 32'd0);
      @(negedge clk);

      // Reset in BUSY, then a late ack.
      req_valid = 1'b1; is_load = 1'b1; trim_ctl = 3'b000; addr = 32'h20;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      check("abort_req_drop", {31'd0, mem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
         check("abort_ready", {31'd0, req_ready}, 32'd1);
      end

      for (int n = 0; n < 60; n++) begin
         bit          ld = 1'($urandom_range(0, 1));
         logic [3:0]  dm = ld ? dms[$urandom_range(0, 3)] : dms[$urandom_range(1, 3)];
         run_op(ld, dm, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 4), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for mem_ack before a bus error is reported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  memory-access stage presents an operation.
REQ-005 req_ready  output  1  operation accepted this cycle; high only in IDLE.
REQ-006 is_load  input  1  operation is a load.
REQ-007 dm_ctl  input  4  store byte mask: 0001 SB, 0011 SH, 1111 SW, 0000 no store.
REQ-008 trim_ctl  input  3  load format: 000 LW, 001 LH, 010 LB, 011 LBU, 100 LHU.
REQ-009 addr  input  32  byte address from the ALU.
REQ-010 wdata  input  32  store data (rs2).
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  trimmed and extended load result; valid with rsp_valid.
REQ-013 misalign_err  output  1  misaligned access; valid with rsp_valid.
REQ-014 bus_err  output  1  timeout; valid with rsp_valid.
REQ-015 mem_req  output  1  memory request, held until acknowledged.
REQ-016 mem_we  output  1  write request.
REQ-017 mem_be  output  4  lane byte enables.
REQ-018 mem_addr  output  30  word address (addr[31:2]).
REQ-019 mem_wdata  output  32  lane-replicated store data.
REQ-020 mem_rdata  input  32  read word; valid when mem_ack is high.
REQ-021 mem_ack  input  1  memory completion.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-023 In IDLE, req_valid with (is_load or dm_ctl != 0) SHALL be accepted; any other req_valid SHALL be ignored with no response.
REQ-024 On accept, the FSM SHALL register addr, mem_be, mem_wdata, trim_ctl and is_load, then go to BUSY; a misaligned access SHALL go directly to RESP with misalign_err set.
REQ-025 Misalignment SHALL be defined as: SH, LH or LHU with addr[0]=1, or SW or LW with addr[1:0] != 00.
REQ-026 mem_be SHALL equal dm_ctl shifted left by addr[1:0] for stores and 1111 for loads; mem_we SHALL equal not is_load.
REQ-027 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-028 In BUSY, mem_req SHALL be 1 with all mem_* outputs stable; mem_ack high SHALL capture mem_rdata and move the FSM to RESP.
REQ-029 In BUSY, a cycle counter SHALL increment each cycle without mem_ack; reaching TIMEOUT_CYC SHALL drop mem_req and move the FSM to RESP with bus_err set.
REQ-030 RESP SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE.
REQ-031 Minimum latency SHALL be: accept in cycle N, mem_req in N+1, mem_ack in N+1, rsp_valid in N+2; a misaligned access SHALL respond in N+1.
REQ-032 The load byte and halfword SHALL be selected by addr[1:0] or addr[1]; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-033 trim_ctl codes 101 to 111 SHALL be treated as LW.
REQ-034 rsp_rdata SHALL be 0 for stores and for any errored response.
REQ-035 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE, the counter SHALL clear, and all outputs SHALL become 0 except req_ready, which SHALL be 1, from the next cycle.
REQ-037 Reset during BUSY SHALL drop mem_req and produce no rsp_valid for the aborted access.

Structure
REQ-038 A shared package SHALL hold the trim_ctl codes, the dm_ctl masks, the state enum and the TIMEOUT_CYC default.
REQ-039 The load extraction SHALL be a combinational sub-module named lsu_load_trim.

Verification
REQ-040 LB at addr 0x103 with mem_rdata 0x80FF_1234 SHALL give mem_be=1111 and rsp_rdata=0xFFFF_FF80.
REQ-041 SH at addr 0x202 with wdata 0x0000_ABCD SHALL give mem_be=1100, mem_wdata=0xABCD_ABCD and mem_we=1.
REQ-042 LW at addr 0x101 SHALL produce no mem_req, and rsp_valid with misalign_err=1 in cycle N+1.
REQ-043 A load with mem_ack held low SHALL give bus_err=1 and rsp_valid=1 after 255 BUSY cycles.
REQ-044 rst asserted during BUSY followed by a late mem_ack SHALL produce no rsp_valid, and req_ready=1 afterwards.
REQ-045 req_valid with is_load=0 and dm_ctl=0000 SHALL produce no mem_req and no rsp_valid, and req_ready SHALL stay 1.
